// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, controller numbers, parser states
// and the per-status data length used by the voice decoder.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] BEND     = 4'hE;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } parser_state_e;

  // Program change and channel aftertouch carry one data byte, the rest two.
  function automatic logic [1:0] data_len(input logic [3:0] nibble);
    if (nibble == PROG || nibble == CH_AT) begin
      return 2'd1;
    end
    return 2'd2;
  endfunction

endpackage

// File: rtl/midi_byte_classifier.sv
// Combinational sorter of a raw MIDI byte into data, realtime,
// system common/SysEx or channel status.
module midi_byte_classifier (
  input  logic [7:0] rx_data_i,
  output logic       is_data_o,
  output logic       is_realtime_o,
  output logic       is_syscommon_o,
  output logic       is_status_o
);

  assign is_data_o      = ~rx_data_i[7];
  assign is_realtime_o  = (rx_data_i[7:3] == 5'b11111);
  assign is_syscommon_o = (rx_data_i[7:3] == 5'b11110);
  assign is_status_o    = rx_data_i[7] & (rx_data_i[7:4] != 4'hF);

endmodule

// File: rtl/midi_voice_decoder.sv
// Monophonic MIDI voice decoder: turns the UART byte stream into note,
// velocity, program and gate controls for the nco, with running status.
module midi_voice_decoder
  import midi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [6:0] note_num_o,
  output logic [6:0] note_vel_o,
  output logic [6:0] program_o,
  output logic       gate_o,
  output logic       note_stb_o
);

  localparam logic [3:0] CH = 4'(CHANNEL);

  parser_state_e state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] note_num_q, note_num_d;
  logic [6:0] note_vel_q, note_vel_d;
  logic [6:0] program_q, program_d;
  logic       gate_q, gate_d;
  logic       note_stb_q, note_stb_d;

  logic is_data, is_realtime, is_syscommon, is_status;

  midi_byte_classifier u_classifier (
    .rx_data_i      (rx_data_i),
    .is_data_o      (is_data),
    .is_realtime_o  (is_realtime),
    .is_syscommon_o (is_syscommon),
    .is_status_o    (is_status)
  );

  logic       complete;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;
  logic       ch_match;

  assign ch_match = OMNI || (status_q[3:0] == CH);

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    d1_d       = d1_q;
    note_num_d = note_num_q;
    note_vel_d = note_vel_q;
    program_d  = program_q;
    gate_d     = gate_q;
    note_stb_d = 1'b0;
    complete   = 1'b0;
    msg_d1     = d1_q;
    msg_d2     = rx_data_i[6:0];

    if (rx_valid_i) begin
      if (is_realtime) begin
        state_d = state_q;
      end else if (is_syscommon) begin
        status_d = 8'h00;
        state_d  = IDLE;
      end else if (is_status) begin
        // Latched even for a foreign channel so running status stays aligned.
        status_d = rx_data_i;
        state_d  = WAIT_D1;
      end else if (is_data) begin
        unique case (state_q)
          WAIT_D1: begin
            d1_d = rx_data_i[6:0];
            if (data_len(status_q[7:4]) == 2'd1) begin
              complete = 1'b1;
              msg_d1   = rx_data_i[6:0];
              msg_d2   = 7'd0;
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            complete = 1'b1;
            state_d  = WAIT_D1;
          end
          default: state_d = state_q;
        endcase
      end
    end

    if (complete && ch_match) begin
      unique case (status_q[7:4])
        NOTE_ON, NOTE_OFF: begin
          if (status_q[7:4] == NOTE_ON && msg_d2 != 7'd0) begin
            note_num_d = msg_d1;
            note_vel_d = msg_d2;
            gate_d     = 1'b1;
            note_stb_d = 1'b1;
          end else if (gate_q && msg_d1 == note_num_q) begin
            gate_d     = 1'b0;
            note_vel_d = 7'd0;
          end
        end
        PROG: program_d = msg_d1;
        CC: begin
          if (msg_d1 == CC_ALL_NOTES_OFF) begin
            gate_d     = 1'b0;
            note_vel_d = 7'd0;
          end
        end
        default: gate_d = gate_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      status_q   <= 8'h00;
      d1_q       <= 7'd0;
      note_num_q <= 7'd0;
      note_vel_q <= 7'd0;
      program_q  <= 7'd0;
      gate_q     <= 1'b0;
      note_stb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      d1_q       <= d1_d;
      note_num_q <= note_num_d;
      note_vel_q <= note_vel_d;
      program_q  <= program_d;
      gate_q     <= gate_d;
      note_stb_q <= note_stb_d;
    end
  end

  assign note_num_o = note_num_q;
  assign note_vel_o = note_vel_q;
  assign program_o  = program_q;
  assign gate_o     = gate_q;
  assign note_stb_o = note_stb_q;

endmodule

// File: tb/tb_midi_voice_decoder.sv
// Scoreboard bench: two decoders (channel 0 only, and omni) fed the same
// byte stream, checked against a behavioural model one cycle after each strobe.
module tb_midi_voice_decoder;

  typedef struct {
    logic [6:0] num;
    logic [6:0] vel;
    logic [6:0] prog;
    logic       gate;
    logic       stb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic [6:0] num0, vel0, prog0, num1, vel1, prog1;
  logic       gate0, stb0, gate1, stb1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state, index 0 = channel-0 decoder, 1 = omni decoder
  logic [7:0] m_rs[2];
  int         m_st[2];
  logic [6:0] m_d1[2];
  exp_t       m_out[2];

  always #5 clk = ~clk;

  midi_voice_decoder #(.CHANNEL(0), .OMNI(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .note_num_o(num0), .note_vel_o(vel0), .program_o(prog0),
    .gate_o(gate0), .note_stb_o(stb0)
  );

  midi_voice_decoder #(.CHANNEL(0), .OMNI(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .note_num_o(num1), .note_vel_o(vel1), .program_o(prog1),
    .gate_o(gate1), .note_stb_o(stb1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rs[k] = 8'h00;
      m_st[k] = 0;
      m_d1[k] = 7'd0;
      m_out[k] = '{num: 7'd0, vel: 7'd0, prog: 7'd0, gate: 1'b0, stb: 1'b0};
    end
  endtask

  task automatic model_complete(input int k, input logic [6:0] a, input logic [6:0] b);
    if (k == 0 && m_rs[k][3:0] != 4'h0) return;
    case (m_rs[k][7:4])
      4'h9, 4'h8: begin
        if (m_rs[k][7:4] == 4'h9 && b != 0) begin
          m_out[k].num  = a;
          m_out[k].vel  = b;
          m_out[k].gate = 1'b1;
          m_out[k].stb  = 1'b1;
        end else if (m_out[k].gate && a == m_out[k].num) begin
          m_out[k].gate = 1'b0;
          m_out[k].vel  = 7'd0;
        end
      end
      4'hC: m_out[k].prog = a;
      4'hB: if (a == 7'd123) begin
        m_out[k].gate = 1'b0;
        m_out[k].vel  = 7'd0;
      end
      default: ;
    endcase
  endtask

  task automatic model_step(input int k, input logic v, input logic [7:0] b);
    m_out[k].stb = 1'b0;
    if (!v || b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_rs[k] = 8'h00;
      m_st[k] = 0;
    end else if (b[7]) begin
      m_rs[k] = b;
      m_st[k] = 1;
    end else if (m_st[k] == 1) begin
      m_d1[k] = b[6:0];
      if (m_rs[k][7:4] == 4'hC || m_rs[k][7:4] == 4'hD) model_complete(k, b[6:0], 7'd0);
      else m_st[k] = 2;
    end else if (m_st[k] == 2) begin
      model_complete(k, m_d1[k], b[6:0]);
      m_st[k] = 1;
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] b);
    @(negedge clk);
    rx_valid = v;
    rx_data  = b;
    model_step(0, v, b);
    model_step(1, v, b);
    q0.push_back(m_out[0]);
    q1.push_back(m_out[1]);
  endtask

  task automatic send(input logic [7:0] bytes[$]);
    foreach (bytes[i]) drive(1'b1, bytes[i]);
    drive(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst.num0", num0, 0);   check("rst.vel0", vel0, 0);
    check("rst.prog0", prog0, 0); check("rst.gate0", gate0, 0);
    check("rst.stb0", stb0, 0);   check("rst.num1", num1, 0);
    check("rst.gate1", gate1, 0); check("rst.stb1", stb1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic compare(input string name, input exp_t e, input logic [6:0] n,
                         input logic [6:0] v, input logic [6:0] p, input logic g, input logic s);
    check({name, ".note_num"}, n, e.num);
    check({name, ".note_vel"}, v, e.vel);
    check({name, ".program"}, p, e.prog);
    check({name, ".gate"}, g, e.gate);
    check({name, ".note_stb"}, s, e.stb);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0 && q1.size() > 0) begin
        exp_t e0, e1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        compare("ch0", e0, num0, vel0, prog0, gate0, stb0);
        compare("omni", e1, num1, vel1, prog1, gate1, stb1);
        $display("t=%0t in=%02h v=%0d ch0 num=%0d vel=%0d prg=%0d g=%0d s=%0d | omni num=%0d vel=%0d prg=%0d g=%0d s=%0d",
                 $time, rx_data, rx_valid, num0, vel0, prog0, gate0, stb0,
                 num1, vel1, prog1, gate1, stb1);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    do_reset();
    send('{8'h90, 8'h3C, 8'h64});
    send('{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50, 8'h3C, 8'h00});
    send('{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C, 8'h00});
    send('{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3D, 8'h00});
    send('{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h00});
    do_reset();
    send('{8'hC0, 8'h05, 8'h91, 8'h3C, 8'h64, 8'h81, 8'h3C, 8'h00});
    send('{8'hC3, 8'h09, 8'hB0, 8'h07, 8'h7F, 8'hA0, 8'h3C, 8'h10, 8'hE0, 8'h00, 8'h40, 8'hD0, 8'h22});
    do_reset();
    send('{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64});
    do_reset();
    send('{8'h90, 8'h3C, 8'hF0, 8'h7F, 8'hF7, 8'h3C, 8'h64});
    send('{8'h90, 8'h3C, 8'hC0, 8'h07, 8'h90, 8'h45, 8'h20});
    send('{8'h90, 8'h30, 8'h40, 8'hB1, 8'h7B, 8'h00, 8'hB0, 8'h7B, 8'h00});
    send('{8'h92, 8'h50, 8'h60, 8'hB2, 8'h7B, 8'h00});
    drive(1'b1, 8'h90);
    do_reset();
    send('{8'h3C, 8'h64});
    for (int i = 0; i < 30; i++) drive(1'b1, 8'($urandom_range(0, 255)));
    drive(1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("queue_empty", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_voice_decoder.md
Name: midi_voice_decoder

Overview:
- Parses a serial MIDI byte stream from the UART receiver, one strobe per byte, into the monophonic voice controls consumed by the nco: NOTE_NUM, NOTE_VEL and PROGRAM.
- Sits between the MIDI UART receiver and the nco.
- Handles running status, channel filtering, note-on with velocity 0, matched note-off, program change and All Notes Off.
- Discards every other message while keeping byte alignment.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) accepted when OMNI=0.
- OMNI, 0, 1 = accept channel voice messages on all channels.

Ports:
- CLK  in  1  system clock (100 MHz).
- RST_N  in  1  asynchronous, active-low reset.
- RX_DATA  in  8  received MIDI byte; valid only when RX_VALID=1.
- RX_VALID  in  1  single-cycle strobe, one per received byte.
- NOTE_NUM  out  7  current note number, to the nco step ROM.
- NOTE_VEL  out  7  current velocity; 0 = silent.
- PROGRAM  out  7  current program (waveform select).
- GATE  out  1  1 while a note is held.
- NOTE_STB  out  1  one-cycle pulse on every accepted note-on.

Behaviour:
- Reset (RST_N=0, asynchronous): NOTE_NUM=0, NOTE_VEL=0, PROGRAM=0, GATE=0, NOTE_STB=0, state IDLE, running status cleared, data-1 register 0.
- Only cycles with RX_VALID=1 advance the parser; other cycles hold all state.
- Byte classes:
  - data: bit7=0.
  - realtime: F8-FF.
  - system common/SysEx: F0-F7.
  - channel status: 80-EF.
- Realtime byte: ignored completely. State, running status and the partial message are untouched, so it may arrive between data bytes.
- System common/SysEx byte: clears running status, goes to IDLE. Following data bytes (SysEx payload) are dropped until the next channel status byte.
- Channel status byte:
  - Always latched as running status, even for a foreign channel.
  - Goes to WAIT_D1.
  - Any partial message in progress is abandoned.
- Data length by status high nibble:
  - 8,9,A,B,E = 2 data bytes.
  - C,D = 1 data byte.
- States:
  - IDLE: no valid running status; data bytes are dropped.
  - WAIT_D1: a data byte is stored in D1. A 1-byte message completes here; otherwise go to WAIT_D2.
  - WAIT_D2: a data byte completes the message. Return to WAIT_D1 (running status); the next data byte starts a new message with the same status.
- Completion actions. These apply only if channel matches (status[3:0]==CHANNEL) or OMNI=1; otherwise the message is parsed and discarded.
  - 9n, vel>0: NOTE_NUM=D1, NOTE_VEL=vel, GATE=1, NOTE_STB=1 for one cycle. Last note wins, including a retrigger while GATE=1.
  - 9n, vel=0: treated exactly as 8n.
  - 8n: if GATE=1 and D1==NOTE_NUM, then GATE=0 and NOTE_VEL=0. A non-matching note-off has no effect. NOTE_NUM is held.
  - Cn: PROGRAM=D1. The note state is unchanged.
  - Bn with D1=123 (All Notes Off): GATE=0, NOTE_VEL=0. Any other controller is ignored.
  - An, Dn, En: ignored.
- Latency: outputs are registered and change on the clock edge that samples the completing RX_VALID byte, so they are visible one cycle after that strobe.
- NOTE_STB is high for exactly one cycle per accepted note-on.
- Back-to-back strobes on consecutive cycles are fully supported; there is no backpressure.
- A status byte arriving in WAIT_D2 discards the pending D1 and never produces a half-formed message.

Decomposition:
- Shared package midi_pkg holds:
  - status nibble constants (NOTE_OFF=8, NOTE_ON=9, POLY_AT=A, CC=B, PROG=C, CH_AT=D, BEND=E);
  - the CC_ALL_NOTES_OFF=123 constant;
  - the parser state enumeration (IDLE, WAIT_D1, WAIT_D2);
  - a function returning the data length for a status nibble.
- Sub-module midi_byte_classifier: combinational; RX_DATA in, is_data/is_realtime/is_syscommon/is_status out. Used by this block and reusable by a future MIDI thru/merger.

Test Plan:
- Reset, then bytes 90 3C 64 (CHANNEL=0) -> NOTE_NUM=60, NOTE_VEL=100, GATE=1, one NOTE_STB pulse; all outputs 0 while RST_N=0.
- 90 3C 64, then running status 40 50, then 3C 00 -> NOTE_NUM=64, NOTE_VEL=80 after the second pair; the third pair leaves GATE=1 (note 60 is not current).
- 90 3C 64 80 3C 00 -> GATE=0, NOTE_VEL=0, NOTE_NUM stays 60; 80 3D 00 instead -> no change.
- C0 05, then 91 3C 64 with OMNI=0 -> PROGRAM=5, no note change and no NOTE_STB; repeat with OMNI=1 -> note accepted.
- 90 F8 3C FE 64 -> realtime bytes ignored, note 60 vel 100 accepted; 90 3C F0 7F F7 3C 64 -> no note output (SysEx clears running status).
- Note held, then B0 7B 00 -> GATE=0, NOTE_VEL=0; RST_N pulsed low between 90 and 3C -> outputs 0, following 3C 64 dropped (IDLE).
